// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - saturating per-frame accumulator for signed Booth multiplier products
module booth_product_accumulator #(
  parameter int N     = 32,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     in_product,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat
);

  localparam int P_W = 2 * N;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              sat;

  logic              accept;
  logic [ACC_W:0]    wide_sum;
  logic              clamp;
  logic [ACC_W-1:0]  nsum;
  logic [CNT_W-1:0]  count_inc;

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  // One guard bit: the two top bits disagree exactly when the sum leaves the ACC_W range.
  assign wide_sum  = {acc[ACC_W-1], acc}
                   + {{(ACC_W+1-P_W){in_product[P_W-1]}}, in_product};
  assign clamp     = wide_sum[ACC_W] != wide_sum[ACC_W-1];
  assign nsum      = !clamp ? wide_sum[ACC_W-1:0]
                   : (wide_sum[ACC_W] ? ACC_MIN : ACC_MAX);
  assign count_inc = (&count) ? count : count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_sum   <= nsum;
              out_count <= count_inc;
              out_sat   <= sat | clamp;
              out_valid <= 1'b1;
              state     <= HOLD;
              acc       <= '0;
              count     <= '0;
              sat       <= 1'b0;
            end else begin
              acc   <= nsum;
              count <= count_inc;
              sat   <= sat | clamp;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
